// File: rtl/vm_pkg.sv
// vm_pkg: shared types and default constants for the vending-machine credit path.
package vm_pkg;

   // Credit FSM states
   typedef enum logic {
      IDLE   = 1'b0,
      REFUND = 1'b1
   } vm_state_t;

   // Default note/coin denominations
   localparam logic [7:0] DEN_2  = 8'd2;
   localparam logic [7:0] DEN_5  = 8'd5;
   localparam logic [7:0] DEN_10 = 8'd10;

   // Default credit ceiling
   localparam int unsigned DEF_MAX_CREDIT = 99;

endpackage

// File: rtl/note_edge_det.sv
// note_edge_det: per-channel rising-edge detector for the note inputs.
// Optional feature macro: NOTE_SYNC_EN adds a 2-flop synchronizer in front of
// the edge detector (2 extra cycles of latency).
module note_edge_det #(
   parameter int unsigned N_CH = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] note,
   output logic [N_CH-1:0] note_rise
);

   logic [N_CH-1:0] note_s;
   logic [N_CH-1:0] note_q;

`ifdef NOTE_SYNC_EN
   logic [N_CH-1:0] sync1;
   logic [N_CH-1:0] sync2;

   // Two-stage synchronizer for asynchronous note inputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= note;
         sync2 <= sync1;
      end
   end

   assign note_s = sync2;
`else
   assign note_s = note;
`endif

   // Previous-cycle copy, tracked every cycle regardless of acceptance state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) note_q <= '0;
      else        note_q <= note_s;
   end

   assign note_rise = note_s & ~note_q;

endmodule

// File: rtl/cash_accumulator_mc.sv
// cash_accumulator_mc: multi-channel credit accumulator with vend and refund
// handshakes. Optional feature macro: NOTE_SYNC_EN (see note_edge_det).
module cash_accumulator_mc
   import vm_pkg::*;
#(
   parameter int unsigned              N_CH       = 3,
   parameter int unsigned              DENOM_W    = 8,
   parameter logic [N_CH*DENOM_W-1:0]  DENOMS     = {DEN_10, DEN_5, DEN_2},
   parameter int unsigned              CW         = 7,
   parameter int unsigned              MAX_CREDIT = DEF_MAX_CREDIT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic [N_CH-1:0] note,
   output logic [N_CH-1:0] note_acc,
   output logic [N_CH-1:0] note_rej,
   output logic [CW-1:0]   credit,
   input  logic            vend_req,
   input  logic [CW-1:0]   vend_price,
   output logic            vend_ok,
   output logic            vend_nak,
   input  logic            refund_req,
   output logic            refund_valid,
   output logic [CW-1:0]   refund_amt,
   input  logic            refund_ack
);

   // Sum width covers credit plus the widest denomination without wrapping
   localparam int unsigned SW = ((CW > DENOM_W) ? CW : DENOM_W) + 1;

   vm_state_t       state, state_d;
   logic [N_CH-1:0] note_rise;
   logic [N_CH-1:0] acc_d, rej_d;
   logic            ok_d, nak_d;
   logic            valid_d;
   logic [CW-1:0]   credit_d, amt_d;
   logic [SW-1:0]   running, cand;

   note_edge_det #(
      .N_CH (N_CH)
   ) u_edge (
      .clk       (clk),
      .rst_n     (rst_n),
      .note      (note),
      .note_rise (note_rise)
   );

   // State, credit and all handshake outputs are registered together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         credit       <= '0;
         note_acc     <= '0;
         note_rej     <= '0;
         vend_ok      <= 1'b0;
         vend_nak     <= 1'b0;
         refund_valid <= 1'b0;
         refund_amt   <= '0;
      end else begin
         state        <= state_d;
         credit       <= credit_d;
         note_acc     <= acc_d;
         note_rej     <= rej_d;
         vend_ok      <= ok_d;
         vend_nak     <= nak_d;
         refund_valid <= valid_d;
         refund_amt   <= amt_d;
      end
   end

   // Next-state, note acceptance and vend/refund decisions
   always_comb begin
      state_d  = state;
      credit_d = credit;
      acc_d    = '0;
      rej_d    = '0;
      ok_d     = 1'b0;
      nak_d    = 1'b0;
      valid_d  = refund_valid;
      amt_d    = refund_amt;
      running  = SW'(credit);
      cand     = '0;
      case (state)
         IDLE: begin
            if (refund_req) begin
               // Notes rising in the refund-entry cycle are ignored so that no
               // accepted credit is lost when the balance is cleared.
               amt_d    = credit;
               credit_d = '0;
               valid_d  = 1'b1;
               state_d  = REFUND;
            end else begin
               if (en) begin
                  for (int unsigned i = 0; i < N_CH; i++) begin
                     if (note_rise[i]) begin
                        cand = running + SW'(DENOMS[i*DENOM_W +: DENOM_W]);
                        if (cand <= SW'(MAX_CREDIT)) begin
                           acc_d[i] = 1'b1;
                           running  = cand;
                        end else begin
                           rej_d[i] = 1'b1;
                        end
                     end
                  end
               end
               // Price compares against pre-update credit, so running >= price
               if (vend_req) begin
                  if (credit >= vend_price) begin
                     ok_d    = 1'b1;
                     running = running - SW'(vend_price);
                  end else begin
                     nak_d = 1'b1;
                  end
               end
               credit_d = running[CW-1:0];
            end
         end
         REFUND: begin
            if (refund_ack) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cash_accumulator_mc.sv
// tb_cash_accumulator_mc: directed and randomized checks of cash_accumulator_mc
// against a behavioural credit model.
module tb_cash_accumulator_mc;

   localparam int MAXC = 99;
`ifdef NOTE_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   int den [3] = '{2, 5, 10};

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [2:0] note;
   logic [2:0] note_acc, note_rej;
   logic [6:0] credit;
   logic       vend_req;
   logic [6:0] vend_price;
   logic       vend_ok, vend_nak;
   logic       refund_req, refund_valid, refund_ack;
   logic [6:0] refund_amt;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int       m_credit, m_amt;
   bit       m_valid, m_refund;
   bit       m_ok, m_nak;
   bit [2:0] m_acc, m_rej, m_prev, m_s1, m_s2;

   cash_accumulator_mc #(
      .N_CH       (3),
      .DENOM_W    (8),
      .DENOMS     ({8'd10, 8'd5, 8'd2}),
      .CW         (7),
      .MAX_CREDIT (99)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .note         (note),
      .note_acc     (note_acc),
      .note_rej     (note_rej),
      .credit       (credit),
      .vend_req     (vend_req),
      .vend_price   (vend_price),
      .vend_ok      (vend_ok),
      .vend_nak     (vend_nak),
      .refund_req   (refund_req),
      .refund_valid (refund_valid),
      .refund_amt   (refund_amt),
      .refund_ack   (refund_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_credit = 0; m_amt = 0; m_valid = 0; m_refund = 0;
      m_ok = 0; m_nak = 0; m_acc = 0; m_rej = 0;
      m_prev = 0; m_s1 = 0; m_s2 = 0;
   endtask

   // One clock of the behavioural model using the currently driven inputs
   task automatic model_step();
      bit [2:0] eff, rise;
      int run;
`ifdef NOTE_SYNC_EN
      eff  = m_s2;
      m_s2 = m_s1;
      m_s1 = note;
`else
      eff  = note;
`endif
      rise   = eff & ~m_prev;
      m_prev = eff;
      m_acc = 0; m_rej = 0; m_ok = 0; m_nak = 0;
      if (!m_refund) begin
         if (refund_req) begin
            m_amt    = m_credit;
            m_credit = 0;
            m_valid  = 1;
            m_refund = 1;
         end else begin
            run = m_credit;
            if (en) begin
               for (int i = 0; i < 3; i++) begin
                  if (rise[i]) begin
                     if (run + den[i] <= MAXC) begin
                        m_acc[i] = 1;
                        run += den[i];
                     end else begin
                        m_rej[i] = 1;
                     end
                  end
               end
            end
            if (vend_req) begin
               if (m_credit >= int'(vend_price)) begin
                  m_ok = 1;
                  run -= int'(vend_price);
               end else begin
                  m_nak = 1;
               end
            end
            m_credit = run;
         end
      end else if (refund_ack) begin
         m_valid  = 0;
         m_refund = 0;
      end
   endtask

   task automatic compare_all();
      check_eq("credit",       credit,       m_credit);
      check_eq("note_acc",     note_acc,     m_acc);
      check_eq("note_rej",     note_rej,     m_rej);
      check_eq("vend_ok",      vend_ok,      m_ok);
      check_eq("vend_nak",     vend_nak,     m_nak);
      check_eq("refund_valid", refund_valid, m_valid);
      check_eq("refund_amt",   refund_amt,   m_amt);
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic run_lat();
      repeat (LAT) cyc();
   endtask

   int cnt;

   initial begin
      rst_n = 1'b0; en = 1'b1; note = '0; vend_req = 1'b0; vend_price = '0;
      refund_req = 1'b0; refund_ack = 1'b0;
      model_reset();
      #11;
      compare_all();
      check_eq("rst_credit", credit, 0);
      check_eq("rst_valid", refund_valid, 0);
      #1 rst_n = 1'b1;

      // one channel rising per step
      note = 3'b001; run_lat();
      check_eq("t1_credit_a", credit, 2);  check_eq("t1_acc_a", note_acc, 3'b001);
      note = 3'b011; run_lat();
      check_eq("t1_credit_b", credit, 7);  check_eq("t1_acc_b", note_acc, 3'b010);
      note = 3'b111; run_lat();
      check_eq("t1_credit_c", credit, 17); check_eq("t1_acc_c", note_acc, 3'b100);

      // vend ok then nak
      vend_req = 1'b1; vend_price = 7'd15; cyc();
      check_eq("vend1_ok", vend_ok, 1); check_eq("vend1_credit", credit, 2);
      vend_req = 1'b0; cyc();
      vend_req = 1'b1; vend_price = 7'd5; cyc();
      check_eq("vend2_nak", vend_nak, 1); check_eq("vend2_ok", vend_ok, 0);
      check_eq("vend2_credit", credit, 2);
      vend_req = 1'b0; cyc();

      // build 12 then refund racing a vend
      note = 3'b011; run_lat();
      note = 3'b111; run_lat();
      check_eq("pre_refund_credit", credit, 12);
      refund_req = 1'b1; vend_req = 1'b1; vend_price = 7'd5; cyc();
      check_eq("rf_valid", refund_valid, 1); check_eq("rf_amt", refund_amt, 12);
      check_eq("rf_credit", credit, 0);
      check_eq("rf_no_ok", vend_ok, 0); check_eq("rf_no_nak", vend_nak, 0);
      refund_req = 1'b0;
      note = 3'b000; run_lat();
      note = 3'b111;
      cnt = 0;
      repeat (LAT + 1) begin
         cyc();
         cnt += int'(note_acc != 0) + int'(note_rej != 0);
      end
      check_eq("rf_no_pulses", cnt, 0);
      check_eq("rf_credit_held", credit, 0);
      check_eq("rf_amt_held", refund_amt, 12);
      refund_ack = 1'b1; cyc();
      check_eq("ack_valid", refund_valid, 0);
      refund_ack = 1'b0; cyc();
      check_eq("pending_vend_nak", vend_nak, 1);
      vend_req = 1'b0; cyc();

      // reach 95, then same-cycle ch0 accept / ch1 reject
      repeat (9) begin
         note = 3'b011; run_lat();
         note = 3'b111; run_lat();
      end
      note = 3'b101; run_lat();
      note = 3'b111; run_lat();
      check_eq("c95", credit, 95);
      note = 3'b100; run_lat();
      note = 3'b111; run_lat();
      check_eq("ceil_credit", credit, 97);
      check_eq("ceil_acc", note_acc, 3'b001);
      check_eq("ceil_rej", note_rej, 3'b010);

      // clear, then held note gives a single accept
      refund_req = 1'b1; cyc(); refund_req = 1'b0;
      refund_ack = 1'b1; cyc(); refund_ack = 1'b0;
      note = 3'b000; run_lat();
      note = 3'b001; cnt = 0;
      repeat (10) begin
         cyc();
         cnt += int'(note_acc[0]);
      end
      check_eq("hold_one_acc", cnt, 1);
      check_eq("hold_credit", credit, 2);
      note = 3'b000; run_lat();
      en = 1'b0; note = 3'b001; run_lat();
      en = 1'b1; cnt = 0;
      repeat (5) begin
         cyc();
         cnt += int'(note_acc != 0);
      end
      check_eq("en_low_no_acc", cnt, 0);
      check_eq("en_low_credit", credit, 2);

      // build 40, enter refund, async reset mid-refund
      refund_req = 1'b1; cyc(); refund_req = 1'b0;
      refund_ack = 1'b1; cyc(); refund_ack = 1'b0;
      note = 3'b000; run_lat();
      repeat (4) begin
         note = 3'b100; run_lat();
         note = 3'b000; run_lat();
      end
      check_eq("c40", credit, 40);
      refund_req = 1'b1; cyc(); refund_req = 1'b0;
      check_eq("rf40_amt", refund_amt, 40);
      cyc();
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check_eq("async_credit", credit, 0);
      check_eq("async_valid", refund_valid, 0);
      check_eq("async_amt", refund_amt, 0);
      #2 rst_n = 1'b1;

      // back in IDLE: first note accepted after the note latency
      note = 3'b001;
      for (int k = 0; k < LAT; k++) begin
         cyc();
         if (k < LAT - 1) check_eq("lat_early", credit, 0);
      end
      check_eq("lat_credit", credit, 2);
      check_eq("lat_acc", note_acc, 3'b001);

      // randomized traffic against the model
      for (int n = 0; n < 800; n++) begin
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 2) == 0) note = note ^ 3'($urandom_range(0, 7));
         vend_req   = ($urandom_range(0, 5) == 0);
         vend_price = 7'($urandom_range(0, 99));
         refund_req = ($urandom_range(0, 24) == 0);
         refund_ack = ($urandom_range(0, 3) == 0);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
